// File: rtl/uart_program_loader.sv
// uart_program_loader: writes a UART byte stream into RAM as big-endian words and acks/naks the host.
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
    parameter int          ADDR_W      = 15,
    parameter int          TIMEOUT_CYC = 3000000,
    parameter logic [7:0]  ACK_BYTE    = 8'hAA,
    parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              loading,
    output logic              done,
    output logic              err
);
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif
    localparam int          TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_REPLY, S_DONE, S_ERR} state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W:0]     r_word_idx, r_len;
    logic [23:0]         r_shift;
    logic [TW-1:0]       r_timer;
    logic [7:0]          r_csum;
    logic                r_nak, r_we, r_tx_start;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                w_active, w_tout, w_fail, w_byte, w_last, w_set_nak, w_counting;
    logic [31:0]         w_word;
    logic [ADDR_W:0]     w_idx_inc;

    assign w_active   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_counting = (r_state != S_LEN) || (r_byte_cnt != 2'd0);
    assign w_tout     = w_active && w_counting && (r_timer == TW'(TIMEOUT_CYC));
    assign w_fail     = w_active && ((rx_ready && rx_ferr) || w_tout);
    // A timeout in the same cycle as a good byte still wins, so the byte is dropped.
    assign w_byte     = w_active && rx_ready && !rx_ferr && !w_tout;
    assign w_last     = w_byte && (r_byte_cnt == 2'd3);
    assign w_word     = {r_shift, rx_data};
    assign w_idx_inc  = r_word_idx + (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LEN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_set_nak = 1'b0;
        case (r_state)
            S_LEN: begin
                if (w_fail) begin
                    w_next    = S_REPLY;
                    w_set_nak = 1'b1;
                end else if (w_last) begin
                    if (w_word == 32'd0) w_next = CS_EN ? S_CSUM : S_REPLY;
                    else if ({1'b0, w_word} > CAP) begin
                        w_next    = S_REPLY;
                        w_set_nak = 1'b1;
                    end else w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fail) begin
                    w_next    = S_REPLY;
                    w_set_nak = 1'b1;
                end else if (w_last && w_idx_inc == r_len) w_next = CS_EN ? S_CSUM : S_REPLY;
            end
            S_CSUM: begin
                if (w_fail) begin
                    w_next    = S_REPLY;
                    w_set_nak = 1'b1;
                end else if (w_byte) begin
                    w_next    = S_REPLY;
                    w_set_nak = rx_data != r_csum;
                end
            end
            S_REPLY: w_next = r_tx_start ? (r_nak ? S_ERR : S_DONE) : S_REPLY;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_timer    <= '0;
            r_csum     <= '0;
            r_nak      <= 1'b0;
            r_we       <= 1'b0;
            r_tx_start <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we       <= 1'b0;
            r_nak      <= r_nak | w_set_nak;
            r_tx_start <= (r_state == S_REPLY) && !tx_busy && !r_tx_start;
            if (w_active) r_timer <= rx_ready ? '0 : (w_counting ? r_timer + TW'(1) : r_timer);
            if (w_byte) begin
                r_shift    <= w_word[23:0];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == S_DATA && w_byte) r_csum <= r_csum ^ rx_data;
            if (r_state == S_LEN && w_last) r_len <= w_word[ADDR_W:0];
            if (r_state == S_DATA && w_last) begin
                r_we       <= 1'b1;
                r_addr     <= r_word_idx[ADDR_W-1:0];
                r_wdata    <= w_word;
                r_word_idx <= w_idx_inc;
            end
        end
    end

    always_comb begin
        loading   = w_active;
        done      = r_state == S_DONE;
        err       = r_state == S_ERR;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        tx_start  = r_tx_start;
        tx_data   = r_tx_start ? (r_nak ? NAK_BYTE : ACK_BYTE) : 8'h00;
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed checks of framing, writes, errors, timeout and reply handshake.
module tb_uart_program_loader;
    localparam int AW = 4;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rx_ferr = 1'b0;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          loading;
    logic          done;
    logic          err;

    int checks = 0;
    int failures = 0;
    logic [AW+31:0] wq[$];
    logic [7:0]     tq[$];

    uart_program_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .loading(loading), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) wq.push_back({mem_addr, mem_wdata});
            if (tx_start) tq.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_ready = 1'b0;
        rx_ferr = 1'b0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        tq.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_data = b;
        rx_ferr = fe;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_ferr = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
    endtask

    task automatic wait_final();
        for (int i = 0; i < 1000 && !(done || err); i++) @(negedge clk);
        check("final_reached", done || err, 1);
    endtask

    task automatic check_end(input string tag, input int nwr, input logic [7:0] reply, input logic ok);
        check({tag, "_nwr"}, wq.size(), nwr);
        check({tag, "_ntx"}, tq.size(), 1);
        check({tag, "_txb"}, tq.size() > 0 ? tq[0] : 8'h00, reply);
        check({tag, "_done"}, done, ok);
        check({tag, "_err"}, err, !ok);
        check({tag, "_loading"}, loading, 0);
    endtask

    initial begin
        do_reset();
        check("rst_loading", loading, 1);
        check("rst_outs", {done, err, mem_we, tx_start, tx_data, mem_addr, mem_wdata}, 0);
        repeat (TO + 50) @(negedge clk);
        check("idle_len_no_timeout", {loading, err, done}, 3'b100);

        // Two-word load; write strobe lands the cycle after the 4th byte.
        do_reset();
        send_word(32'd2);
        for (int i = 3; i >= 1; i--) send_byte(8'(32'h20010005 >> (i*8)), 1'b0);
        send_byte(8'h05, 1'b0);
        check("t1_we_timing", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 32'h20010005});
        send_word(32'hAC010000);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h89, 1'b0);
`endif
        wait_final();
        check("t1_w0", wq.size() > 0 ? wq[0] : '1, {4'd0, 32'h20010005});
        check("t1_w1", wq.size() > 1 ? wq[1] : '1, {4'd1, 32'hAC010000});
        check_end("t1", 2, 8'hAA, 1);
        send_word(32'h12345678);
        repeat (3) @(negedge clk);
        check("t1_ignore_after_done", {wq.size() == 2, tq.size() == 1, done, err}, 4'b1110);

        do_reset();
        send_word(32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_final();
        check_end("t2", 0, 8'hAA, 1);

        do_reset();
        send_word(32'd2);
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b0);
        wait_final();
        check_end("t3", 0, 8'hEE, 0);

        do_reset();
        send_word(32'd17);
        wait_final();
        check_end("t4", 0, 8'hEE, 0);

        do_reset();
        send_word(32'd16);
        wait_final();
        check("t4b_max_len_not_final", {done, err}, 2'b01);
        check("t4b_nwr", wq.size(), 0);

        do_reset();
        send_word(32'd2);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        repeat (TO - 50) @(negedge clk);
        check("t5_still_loading", {loading, err}, 2'b10);
        wait_final();
        check("t5_w0", wq.size() > 0 ? wq[0] : '1, {4'd0, 32'h11223344});
        check_end("t5", 1, 8'hEE, 0);

        do_reset();
        send_word(32'd1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h78, 1'b0);
        tx_busy = 1'b1;
        send_byte(8'h08, 1'b0);
`else
        tx_busy = 1'b1;
        send_byte(8'h78, 1'b0);
`endif
        repeat (100) @(negedge clk);
        check("t6_held", {tq.size() == 0, tx_start, done, err, loading}, 5'b10000);
        tx_busy = 1'b0;
        @(negedge clk);
        check("t6_start", {tx_start, tx_data}, {1'b1, 8'hAA});
        @(negedge clk);
        check("t6_after", {tx_start, done}, 2'b01);
        check_end("t6", 1, 8'hAA, 1);

`ifdef UART_LOADER_CHECKSUM_EN
        do_reset();
        send_word(32'd1);
        send_word(32'h12345678);
        send_byte(8'h09, 1'b0);
        wait_final();
        check_end("t7_badcsum", 1, 8'hEE, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
